// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port memory with a fixed read latency.
// Writes stream in over valid/ready; reads return through a credit-limited FWFT FIFO.
module mem_burst_master #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W:0]   req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cmd_en,
  output logic              mem_cmd,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_data_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  generate
    if (FIFO_DEPTH < RD_LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("FIFO_DEPTH must be a power of two and at least RD_LAT+2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
  logic [LEN_W-1:0]    remain_reg, remain_next;
  logic [CNT_W-1:0]    out_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic                cmd_en_reg, cmd_en_next;
  logic                cmd_reg, cmd_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic                done_reg, done_next;
  logic                issue, push, pop;
  logic [OCC_W-1:0]    occupancy;

  assign req_ready   = (state_reg == IDLE) && !rst;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign mem_cmd_en  = cmd_en_reg;
  assign mem_cmd     = cmd_reg;
  assign mem_addr    = addr_reg;
  assign mem_wr_data = wr_data_reg;
  assign rdata_valid = (count_reg != '0);
  assign rdata       = fifo_mem[rd_ptr_reg];

  // Returns with nothing outstanding are stale (e.g. issued before a reset).
  assign push = mem_rd_data_valid && (out_reg != '0);
  assign pop  = rdata_valid && rdata_ready;

  // A slot being popped this cycle is free by the time the new read can return.
  assign occupancy = OCC_W'(out_reg) + OCC_W'(count_reg) - OCC_W'(pop);

  always_comb begin
    state_next    = state_reg;
    cur_addr_next = cur_addr_reg;
    remain_next   = remain_reg;
    cmd_en_next   = 1'b0;
    cmd_next      = cmd_reg;
    addr_next     = addr_reg;
    wr_data_next  = wr_data_reg;
    done_next     = 1'b0;
    wdata_ready   = 1'b0;
    issue         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready) begin
          cur_addr_next = req_addr;
          remain_next   = req_len;
          if (req_len == '0) done_next = 1'b1;
          else               state_next = req_wr ? WR : RD;
        end
      end
      WR: begin
        wdata_ready = (remain_reg != '0);
        if (wdata_valid && wdata_ready) begin
          cmd_en_next   = 1'b1;
          cmd_next      = 1'b1;
          addr_next     = cur_addr_reg;
          wr_data_next  = wdata;
          cur_addr_next = cur_addr_reg + ADDR_W'(1);
          remain_next   = remain_reg - LEN_W'(1);
          if (remain_reg == LEN_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      RD: begin
        if (remain_reg != '0 && occupancy < OCC_W'(FIFO_DEPTH)) begin
          issue         = 1'b1;
          cmd_en_next   = 1'b1;
          cmd_next      = 1'b0;
          addr_next     = cur_addr_reg;
          cur_addr_next = cur_addr_reg + ADDR_W'(1);
          remain_next   = remain_reg - LEN_W'(1);
          if (remain_reg == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_reg == '0 && (count_reg == '0 || (count_reg == CNT_W'(1) && pop))) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cur_addr_reg <= '0;
      remain_reg   <= '0;
      out_reg      <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cmd_en_reg   <= 1'b0;
      cmd_reg      <= 1'b0;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      remain_reg   <= remain_next;
      cmd_en_reg   <= cmd_en_next;
      cmd_reg      <= cmd_next;
      addr_reg     <= addr_next;
      wr_data_reg  <= wr_data_next;
      done_reg     <= done_next;
      if (issue && !push)      out_reg <= out_reg + CNT_W'(1);
      else if (push && !issue) out_reg <= out_reg - CNT_W'(1);
      if (push && !pop)        count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push)   count_reg <= count_reg - CNT_W'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_rd_data;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Scoreboard bench for mem_burst_master with a 2-cycle-latency memory model.
module tb_mem_burst_master;
  localparam int DW = 512;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [AW:0]   req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata;
  logic          busy, done;
  logic [AW-1:0] mem_addr;
  logic          mem_cmd_en, mem_cmd;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          mem_rd_data_valid;

  mem_burst_master #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;

  cmd_t          exp_cmd_q[$];
  logic [DW-1:0] exp_rd_q[$];
  int            cmd_cycles[$], rv_cycles[$], done_cycles[$];
  int            cyc = 0;
  int            n_checks = 0, n_errors = 0;

  logic [DW-1:0] mem_model [1 << AW];
  logic [DW-1:0] ref_mem   [1 << AW];
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [DW-1:0] d1, d2;

  assign mem_rd_data_valid = v2;
  assign mem_rd_data       = d2;

  // Memory model is deliberately not reset so in-flight returns survive a DUT reset.
  always @(posedge clk) begin
    v1 <= mem_cmd_en && !mem_cmd;
    d1 <= mem_model[mem_addr];
    v2 <= v1;
    d2 <= d1;
    if (mem_cmd_en && mem_cmd) mem_model[mem_addr] <= mem_wr_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = 32'(i) * 32'h9E3779B1 + 32'(j);
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_cmd_en) begin
        cmd_cycles.push_back(cyc);
        if (exp_cmd_q.size() == 0) check("cmd_extra", DW'(mem_cmd_en), DW'(0));
        else begin
          cmd_t e;
          e = exp_cmd_q.pop_front();
          $display("cmd  cyc=%0d dir=%0d addr=%0h", cyc, mem_cmd, mem_addr);
          check("cmd_dir", DW'(mem_cmd), DW'(e.wr));
          check("cmd_addr", DW'(mem_addr), DW'(e.addr));
          if (e.wr) check("cmd_wdata", mem_wr_data, e.data);
        end
      end
      if (rdata_valid) rv_cycles.push_back(cyc);
      if (rdata_valid && rdata_ready) begin
        if (exp_rd_q.size() == 0) check("rdata_extra", DW'(rdata_valid), DW'(0));
        else begin
          $display("rd   cyc=%0d data=%0h", cyc, rdata[31:0]);
          check("rdata", rdata, exp_rd_q.pop_front());
        end
      end
      if (done) done_cycles.push_back(cyc);
    end
  end

  task automatic clear_logs();
    cmd_cycles.delete();
    rv_cycles.delete();
    done_cycles.delete();
  endtask

  task automatic send_req(input logic wr, input logic [AW-1:0] addr, input logic [AW:0] len);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_len = len;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", DW'(req_ready), DW'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      cmd_t e;
      a = addr + AW'(i);
      e.wr = 1'b0; e.addr = a; e.data = '0;
      exp_cmd_q.push_back(e);
      exp_rd_q.push_back(ref_mem[a]);
    end
    send_req(1'b0, addr, (AW+1)'(len));
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input int len,
                             input logic [15:0] vpat, input int npat);
    logic [AW-1:0] a = addr;
    int k = 0, i = 0;
    send_req(1'b1, addr, (AW+1)'(len));
    while (k < len && i < 200) begin
      wdata_valid = (i < npat) ? vpat[i] : 1'b1;
      wdata = rand_word();
      @(negedge clk);
      if (wdata_valid && wdata_ready) begin
        cmd_t e;
        e.wr = 1'b1; e.addr = a; e.data = wdata;
        exp_cmd_q.push_back(e);
        ref_mem[a] = wdata;
        a = a + AW'(1);
        k++;
      end
      @(posedge clk); #1;
      i++;
    end
    wdata_valid = 1'b0;
    check("wr_beats_accepted", DW'(k), DW'(len));
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cycles.size() < target && n < budget) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check(tag, DW'(done_cycles.size()), DW'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem_model[i] = pat(i);
      ref_mem[i]   = pat(i);
    end
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_cmd_en", DW'(mem_cmd_en), DW'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", DW'(req_ready), DW'(1));
    check("idle_busy", DW'(busy), DW'(0));
    check("idle_done", DW'(done), DW'(0));
    check("idle_wdata_ready", DW'(wdata_ready), DW'(0));
    check("idle_rdata_valid", DW'(rdata_valid), DW'(0));
    check("idle_mem_cmd", DW'(mem_cmd), DW'(0));
    check("idle_mem_addr", DW'(mem_addr), DW'(0));
    check("idle_mem_wr_data", mem_wr_data, DW'(0));

    // Write with address wrap, back-to-back beats
    clear_logs();
    write_burst(AW'(10'h3FE), 4, 16'hFFFF, 16);
    wait_done(1, 20, "wrap_done_count");
    check("wrap_cmds", DW'(cmd_cycles.size()), DW'(4));
    check("wrap_consecutive", DW'(cmd_cycles[3] - cmd_cycles[0]), DW'(3));
    check("wrap_done_cycle", DW'(done_cycles[0]), DW'(cmd_cycles[3]));

    // Read with backpressure: credits stop issue at 4
    clear_logs();
    rdata_ready = 1'b0;
    read_burst(AW'(0), 8);
    repeat (30) @(negedge clk);
    check("bp_cmds_stalled", DW'(cmd_cycles.size()), DW'(4));
    check("bp_cmd_idle", DW'(mem_cmd_en), DW'(0));
    check("bp_rdata_valid", DW'(rdata_valid), DW'(1));
    @(posedge clk); #1 rdata_ready = 1'b1;
    wait_done(1, 100, "bp_done_count");
    check("bp_cmds_total", DW'(cmd_cycles.size()), DW'(8));
    check("bp_rd_q_empty", DW'(exp_rd_q.size()), DW'(0));

    // Full-rate read
    clear_logs();
    read_burst(AW'(10'h100), 16);
    wait_done(1, 100, "fr_done_count");
    check("fr_cmds", DW'(cmd_cycles.size()), DW'(16));
    check("fr_cmd_span", DW'(cmd_cycles[15] - cmd_cycles[0]), DW'(15));
    check("fr_rv_count", DW'(rv_cycles.size()), DW'(16));
    check("fr_rv_start", DW'(rv_cycles[0] - cmd_cycles[0]), DW'(3));
    check("fr_rv_span", DW'(rv_cycles[15] - rv_cycles[0]), DW'(15));
    check("fr_rd_q_empty", DW'(exp_rd_q.size()), DW'(0));

    // Zero-length in both directions
    for (int d = 0; d < 2; d++) begin
      clear_logs();
      send_req(d[0], AW'(5), '0);
      @(negedge clk);
      check("zl_done_next_cycle", DW'(done), DW'(1));
      check("zl_busy", DW'(busy), DW'(0));
      repeat (4) @(negedge clk);
      check("zl_no_cmds", DW'(cmd_cycles.size()), DW'(0));
      check("zl_done_once", DW'(done_cycles.size()), DW'(1));
    end

    // Gapped write: valid pattern 1,0,0,1,1
    clear_logs();
    write_burst(AW'(10'h040), 3, 16'b11001, 5);
    wait_done(1, 20, "gap_done_count");
    check("gap_cmds", DW'(cmd_cycles.size()), DW'(3));
    check("gap_gap1", DW'(cmd_cycles[1] - cmd_cycles[0]), DW'(3));
    check("gap_gap2", DW'(cmd_cycles[2] - cmd_cycles[0]), DW'(4));

    // Reset in the middle of a read
    clear_logs();
    rdata_ready = 1'b0;
    read_burst(AW'(10'h200), 8);
    for (int n = 0; n < 50 && cmd_cycles.size() < 3; n++) @(negedge clk);
    check("mr_three_cmds", DW'(cmd_cycles.size() >= 3), DW'(1));
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cmd_q.delete();
    exp_rd_q.delete();
    @(negedge clk);
    check("mr_rdata_valid", DW'(rdata_valid), DW'(0));
    check("mr_cmd_en", DW'(mem_cmd_en), DW'(0));
    check("mr_busy", DW'(busy), DW'(0));
    repeat (6) @(negedge clk);
    check("mr_late_dropped", DW'(rdata_valid), DW'(0));
    check("mr_no_done", DW'(done_cycles.size()), DW'(0));
    @(posedge clk); #1 rdata_ready = 1'b1;
    clear_logs();
    read_burst(AW'(10'h3FF), 2);
    wait_done(1, 50, "mr_post_done_count");
    check("mr_post_cmds", DW'(cmd_cycles.size()), DW'(2));
    check("mr_post_rd_q_empty", DW'(exp_rd_q.size()), DW'(0));
    check("final_cmd_q_empty", DW'(exp_cmd_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
